// File: rtl/c17_bist_ctrl.sv
// BIST harness for the C17 benchmark: LFSR stimulus, MISR response compaction, golden compare.
// Optional macro C17_BIST_ZERO_PAT_EN appends one all-zero pattern after the LFSR sequence.
module c17_bist_ctrl #(
  parameter int unsigned        N_PATTERNS = 31,
  parameter logic [4:0]         SEED       = 5'b00001,
  parameter int unsigned        MISR_W     = 16,
  parameter logic [MISR_W-1:0]  MISR_POLY  = MISR_W'(16'h1021)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  output logic [4:0]        pat_out,
  output logic              pat_valid,
  input  logic [1:0]        resp_in,
  input  logic [MISR_W-1:0] golden_sig,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [MISR_W-1:0] signature
);

  typedef enum logic [1:0] {StIdle, StLoad, StRun, StDone} state_e;

  localparam logic [5:0] LastIdx = 6'(N_PATTERNS - 1);

  state_e            state_q, state_d;
  logic [4:0]        lfsr_q;
  logic [4:0]        pat_hold_q;
  logic [5:0]        count_q;
  logic [MISR_W-1:0] sig_q;
  logic [MISR_W-1:0] misr_next;
  logic              pass_q;
  logic              last_lfsr;
  logic              run_end;
  logic [4:0]        pattern_cur;

`ifdef C17_BIST_ZERO_PAT_EN
  logic zero_q;
  assign pattern_cur = zero_q ? 5'b00000 : lfsr_q;
  assign run_end     = zero_q;
`else
  assign pattern_cur = lfsr_q;
  assign run_end     = last_lfsr;
`endif

  assign last_lfsr = (count_q == LastIdx);

  always_comb begin
    misr_next = {sig_q[MISR_W-2:0], 1'b0}
              ^ (sig_q[MISR_W-1] ? MISR_POLY : '0)
              ^ {{(MISR_W-2){1'b0}}, resp_in};
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StLoad;
      StLoad:  state_d = StRun;
      StRun:   if (run_end) state_d = StDone;
      StDone:  if (start) state_d = StLoad;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy      = (state_q == StLoad) || (state_q == StRun);
    pat_valid = (state_q == StRun);
    done      = (state_q == StDone);
    pass      = pass_q && (state_q == StDone);
    // Outside RUN the last applied pattern stays visible.
    pat_out   = (state_q == StRun) ? pattern_cur : pat_hold_q;
    signature = sig_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      lfsr_q     <= 5'b00000;
      pat_hold_q <= 5'b00000;
      count_q    <= 6'd0;
      sig_q      <= '0;
      pass_q     <= 1'b0;
`ifdef C17_BIST_ZERO_PAT_EN
      zero_q     <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      case (state_q)
        StLoad: begin
          lfsr_q  <= SEED;
          sig_q   <= '0;
          count_q <= 6'd0;
          pass_q  <= 1'b0;
`ifdef C17_BIST_ZERO_PAT_EN
          zero_q  <= 1'b0;
`endif
        end
        StRun: begin
          sig_q      <= misr_next;
          lfsr_q     <= {lfsr_q[3:0], lfsr_q[4] ^ lfsr_q[2]};
          count_q    <= count_q + 6'd1;
          pat_hold_q <= pattern_cur;
`ifdef C17_BIST_ZERO_PAT_EN
          if (last_lfsr) zero_q <= 1'b1;
`endif
          // Compare the signature that includes the final pattern's response.
          if (run_end) pass_q <= (misr_next == golden_sig);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_c17_bist_ctrl.sv
// Self-checking bench for c17_bist_ctrl: four instances with different pattern counts,
// table-driven runs, hand-written corner sequences and randomized responses vs. a model.
module tb_c17_bist_ctrl;

  localparam int ND = 4;
  localparam int unsigned NP [ND] = '{6, 2, 31, 1};
`ifdef C17_BIST_ZERO_PAT_EN
  localparam int ZP = 1;
`else
  localparam int ZP = 0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        start     [ND];
  logic [1:0]  resp_drv  [ND];
  logic        resp_c17  [ND];
  logic [1:0]  resp      [ND];
  logic [15:0] golden    [ND];
  logic [4:0]  pat_out   [ND];
  logic        pat_valid [ND];
  logic        busy      [ND];
  logic        done      [ND];
  logic        pass      [ND];
  logic [15:0] signature [ND];

  int vectors = 0;
  int errors  = 0;

  function automatic logic [1:0] c17(input logic [4:0] p);
    logic g1, g2, g3, g6, g7, n10, n11, n16, n19;
    {g1, g2, g3, g6, g7} = p;
    n10 = ~(g1 & g3);
    n11 = ~(g3 & g6);
    n16 = ~(g2 & n11);
    n19 = ~(n11 & g7);
    return {~(n10 & n16), ~(n16 & n19)};
  endfunction

  for (genvar g = 0; g < ND; g++) begin : g_dut
    assign resp[g] = resp_c17[g] ? c17(pat_out[g]) : resp_drv[g];
    c17_bist_ctrl #(.N_PATTERNS(NP[g])) u_dut (
      .clock      (clock),
      .reset      (reset),
      .start      (start[g]),
      .pat_out    (pat_out[g]),
      .pat_valid  (pat_valid[g]),
      .resp_in    (resp[g]),
      .golden_sig (golden[g]),
      .busy       (busy[g]),
      .done       (done[g]),
      .pass       (pass[g]),
      .signature  (signature[g])
    );
  end

  always #5 clock = ~clock;

  // Pattern i of a run with n LFSR patterns; indices past n are the optional zero pattern.
  function automatic logic [4:0] exp_pat(input int i, input int n);
    logic [4:0] x;
    if (i >= n) return 5'b00000;
    x = 5'b00001;
    for (int k = 0; k < i; k++) x = {x[3:0], x[4] ^ x[2]};
    return x;
  endfunction

  function automatic logic [15:0] misr(input logic [15:0] s, input logic [1:0] r);
    return (s << 1) ^ (s[15] ? 16'h1021 : 16'h0000) ^ {14'b0, r};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // rmode: 0 forced resp_drv, 1 real C17, 2 random per cycle.
  task automatic run(input int d, input int rmode, input bit auto_gold, input bit poke_start,
                     output logic [15:0] sig);
    int total;
    logic [4:0] p;
    logic [1:0] r;
    total = int'(NP[d]) + ZP;
    sig = 16'h0000;
    @(negedge clock);
    start[d]    = 1'b1;
    resp_c17[d] = (rmode == 1);
    @(negedge clock);
    start[d] = 1'b0;
    #1;
    chk($sformatf("load_busy[%0d]", d), 32'(busy[d]), 32'd1);
    chk($sformatf("load_valid[%0d]", d), 32'(pat_valid[d]), 32'd0);
    for (int i = 0; i < total; i++) begin
      @(negedge clock);
      p = exp_pat(i, int'(NP[d]));
      if (rmode == 2) resp_drv[d] = 2'($urandom_range(0, 3));
      start[d] = poke_start && (i == 1 || i == total - 1);
      #1;
      r = (rmode == 1) ? c17(p) : resp_drv[d];
      chk($sformatf("run_pat[%0d] i=%0d", d, i), 32'(pat_out[d]), 32'(p));
      chk($sformatf("run_valid[%0d] i=%0d", d, i), 32'(pat_valid[d]), 32'd1);
      chk($sformatf("run_sig[%0d] i=%0d", d, i), 32'(signature[d]), 32'(sig));
      sig = misr(sig, r);
      if (auto_gold && i == total - 1) golden[d] = sig;
    end
    @(negedge clock);
    start[d] = 1'b0;
    #1;
    chk($sformatf("end_done[%0d]", d), 32'(done[d]), 32'd1);
    chk($sformatf("end_busy[%0d]", d), 32'(busy[d]), 32'd0);
    chk($sformatf("end_valid[%0d]", d), 32'(pat_valid[d]), 32'd0);
    chk($sformatf("end_sig[%0d]", d), 32'(signature[d]), 32'(sig));
    chk($sformatf("end_pass[%0d]", d), 32'(pass[d]), 32'(sig == golden[d]));
    chk($sformatf("end_pat[%0d]", d), 32'(pat_out[d]), 32'(exp_pat(total - 1, int'(NP[d]))));
  endtask

  typedef struct {
    logic [1:0]  resp;
    logic [15:0] gold;
    logic [15:0] sig;
    logic        pas;
  } vec_t;

  initial begin
    vec_t        tbl [6];
    logic [15:0] s, s1;
    logic [4:0]  seq6 [6];
    logic [4:0]  got [$];
    int          nbusy, ndone, nvalid, donecyc;

`ifdef C17_BIST_ZERO_PAT_EN
    tbl = '{'{2'b01, 16'h0007, 16'h0007, 1'b1}, '{2'b01, 16'h0004, 16'h0007, 1'b0},
            '{2'b10, 16'h000E, 16'h000E, 1'b1}, '{2'b11, 16'h0009, 16'h0009, 1'b1},
            '{2'b00, 16'h0000, 16'h0000, 1'b1}, '{2'b11, 16'h0006, 16'h0009, 1'b0}};
`else
    tbl = '{'{2'b01, 16'h0003, 16'h0003, 1'b1}, '{2'b01, 16'h0004, 16'h0003, 1'b0},
            '{2'b10, 16'h0006, 16'h0006, 1'b1}, '{2'b11, 16'h0005, 16'h0005, 1'b1},
            '{2'b00, 16'h0000, 16'h0000, 1'b1}, '{2'b11, 16'h0006, 16'h0005, 1'b0}};
`endif
    seq6 = '{5'b00001, 5'b00010, 5'b00100, 5'b01001, 5'b10010, 5'b00101};

    reset = 1'b1;
    for (int d = 0; d < ND; d++) begin
      start[d] = 1'b0; resp_drv[d] = 2'b00; resp_c17[d] = 1'b0; golden[d] = 16'h0000;
    end
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (5) @(negedge clock);
    #1;
    for (int d = 0; d < ND; d++) begin
      chk($sformatf("rst_busy[%0d]", d), 32'(busy[d]), 32'd0);
      chk($sformatf("rst_done[%0d]", d), 32'(done[d]), 32'd0);
      chk($sformatf("rst_pass[%0d]", d), 32'(pass[d]), 32'd0);
      chk($sformatf("rst_valid[%0d]", d), 32'(pat_valid[d]), 32'd0);
      chk($sformatf("rst_sig[%0d]", d), 32'(signature[d]), 32'd0);
      chk($sformatf("rst_pat[%0d]", d), 32'(pat_out[d]), 32'd0);
    end

    // N=6: capture pattern stream, busy length and done latency.
    @(negedge clock);
    start[0] = 1'b1;
    nbusy = 0; nvalid = 0; donecyc = -1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clock);
      start[0] = 1'b0;
      #1;
      if (busy[0]) nbusy++;
      if (pat_valid[0]) begin nvalid++; got.push_back(pat_out[0]); end
      if (done[0] && donecyc < 0) donecyc = c;
    end
    for (int i = 0; i < 6; i++)
      chk($sformatf("seq6[%0d]", i), 32'(got.size() > i ? got[i] : 5'h1f), 32'(seq6[i]));
    chk("seq6_nvalid", 32'(nvalid), 32'(6 + ZP));
    chk("seq6_busy", 32'(nbusy), 32'(7 + ZP));
    chk("seq6_done_cycle", 32'(donecyc), 32'(7 + ZP));

    // N=2 table of forced responses and golden values.
    for (int t = 0; t < 6; t++) begin
      resp_drv[1] = tbl[t].resp;
      golden[1]   = tbl[t].gold;
      run(1, 0, 1'b0, 1'b0, s);
      chk($sformatf("tbl_sig[%0d]", t), 32'(signature[1]), 32'(tbl[t].sig));
      chk($sformatf("tbl_pass[%0d]", t), 32'(pass[1]), 32'(tbl[t].pas));
      golden[1] = ~golden[1];
      @(negedge clock);
      #1;
      chk($sformatf("tbl_pass_hold[%0d]", t), 32'(pass[1]), 32'(tbl[t].pas));
    end

    // start held high restarts after every DONE.
    resp_drv[1] = 2'b01;
    @(negedge clock);
    start[1] = 1'b1;
    nbusy = 0; ndone = 0;
    for (int c = 0; c < 3 * (4 + ZP); c++) begin
      @(negedge clock);
      if (c == 3 * (4 + ZP) - 1) start[1] = 1'b0;
      #1;
      if (busy[1]) nbusy++;
      if (done[1]) ndone++;
    end
    chk("hold_start_done", 32'(ndone), 32'd3);
    chk("hold_start_busy", 32'(nbusy), 32'(3 * (3 + ZP)));
    chk("hold_start_final_done", 32'(done[1]), 32'd1);

    // All-zero responses with start pokes during RUN.
    resp_drv[2] = 2'b00;
    golden[2]   = 16'h0000;
    run(2, 0, 1'b0, 1'b1, s);
    chk("zero_resp_sig", 32'(signature[2]), 32'd0);
    chk("zero_resp_pass", 32'(pass[2]), 32'd1);

    // Real C17, then a repeat run must give the same signature.
    run(2, 1, 1'b1, 1'b0, s1);
    chk("c17_pass", 32'(pass[2]), 32'd1);
    run(2, 1, 1'b0, 1'b0, s);
    chk("c17_repeat_sig", 32'(signature[2]), 32'(s1));
    chk("c17_repeat_pass", 32'(pass[2]), 32'd1);

    // Randomized responses against the model.
    for (int k = 0; k < 4; k++) begin
      golden[2] = 16'($urandom);
      run(2, 2, (k % 2) == 0, 1'b0, s);
    end

    // N=1 with response 10 (two patterns when the zero pattern is enabled).
    resp_drv[3] = 2'b10;
    golden[3]   = (ZP != 0) ? 16'h0006 : 16'h0002;
    run(3, 0, 1'b0, 1'b0, s);
    chk("n1_sig", 32'(signature[3]), (ZP != 0) ? 32'h6 : 32'h2);
    chk("n1_pass", 32'(pass[3]), 32'd1);

    // Asynchronous reset in the middle of a run.
    resp_c17[2] = 1'b1;
    @(negedge clock);
    start[2] = 1'b1;
    @(negedge clock);
    start[2] = 1'b0;
    repeat (4) @(negedge clock);
    #1;
    chk("pre_reset_busy", 32'(busy[2]), 32'd1);
    #1;
    reset = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(busy[2]), 32'd0);
    chk("mid_rst_valid", 32'(pat_valid[2]), 32'd0);
    chk("mid_rst_done", 32'(done[2]), 32'd0);
    chk("mid_rst_pass", 32'(pass[2]), 32'd0);
    chk("mid_rst_sig", 32'(signature[2]), 32'd0);
    chk("mid_rst_pat", 32'(pat_out[2]), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    #1;
    chk("post_rst_busy", 32'(busy[2]), 32'd0);
    chk("post_rst_done", 32'(done[2]), 32'd0);
    run(2, 1, 1'b1, 1'b0, s);
    chk("post_rst_sig", 32'(signature[2]), 32'(s1));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  // Global bound so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL timeout: got running, want finished");
    $fatal(1, "timeout");
  end

endmodule
